// File: rtl/mul_acc_frame_pipe.sv
// mul_acc_frame_pipe
//   Pipelined multiply-accumulate engine. Takes a valid/ready stream of unsigned (a,b)
//   operand pairs, zeroes the NAB LSBs of each operand to approximate the datapath,
//   multiplies them, sums NLEN products per frame and presents each frame sum with an
//   overflow flag through a valid/ready output register.
//   Pipeline: accept edge loads the masked product into S1; the next edge folds S1 into
//   the accumulator, or on the frame's last product loads the output register.
//   Optional feature: define MUL_ACC_SAT_EN to saturate the accumulator to all ones on
//   overflow; left undefined, the accumulator wraps modulo 2^ACCW. In both builds ovf
//   flags the overflowing frame.
module mul_acc_frame_pipe #(
    parameter int BWOP = 32,
    parameter int NAB  = 0,
    parameter int NLEN = 4,
    parameter int ACCW = 2*BWOP+8
) (
    input  logic            clk,
    input  logic            rst,        // asynchronous, active low
    input  logic            clr,        // synchronous frame abort
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BWOP-1:0] a,
    input  logic [BWOP-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] c,
    output logic            ovf
);

    localparam int              CNTW      = (NLEN > 1) ? $clog2(NLEN) : 1;
    localparam logic [CNTW-1:0] LAST_CNT  = CNTW'(NLEN - 1);
    // Operand bits that survive the approximation mask.
    localparam logic [BWOP-1:0] MASK_KEEP = ~((BWOP'(1) << NAB) - BWOP'(1));

    // Frame position and S1 (product stage) registers.
    logic [CNTW-1:0]   r_cnt;
    logic              r_s1_valid;
    logic              r_s1_last;
    logic [2*BWOP-1:0] r_s1_prod;

    // Accumulator and sticky overflow for the frame in progress.
    logic [ACCW-1:0]   r_acc;
    logic              r_frame_ovf;

    // Output register.
    logic              r_out_valid;
    logic [ACCW-1:0]   r_c;
    logic              r_ovf;

    logic              w_stall;
    logic              w_accept;
    logic              w_last;
    logic [2*BWOP-1:0] w_a_ext;
    logic [2*BWOP-1:0] w_b_ext;
    logic [2*BWOP-1:0] w_prod;
    logic [ACCW:0]     w_sum;
    logic              w_carry;
    logic [ACCW-1:0]   w_acc_nxt;
    logic              w_frame_ovf_nxt;
    logic              w_load;

    // A result waiting on a busy consumer freezes the whole pipeline.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall && !clr;
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == LAST_CNT);

    // Masked operands are zero-extended first so the product keeps all 2*BWOP bits.
    assign w_a_ext  = (2*BWOP)'(a & MASK_KEEP);
    assign w_b_ext  = (2*BWOP)'(b & MASK_KEEP);
    assign w_prod   = w_a_ext * w_b_ext;

    // One extra bit on the adder exposes the carry out of ACCW.
    assign w_sum    = {1'b0, r_acc} + (ACCW+1)'(r_s1_prod);
    assign w_carry  = w_sum[ACCW];

    // The frame's last S1 entry goes to the output register instead of the accumulator.
    assign w_load   = r_s1_valid && r_s1_last && !w_stall && !clr;

    // Next accumulator value and sticky overflow after adding the S1 product.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        w_frame_ovf_nxt = r_frame_ovf | w_carry;
        w_acc_nxt       = w_sum[ACCW-1:0];
`ifdef MUL_ACC_SAT_EN
        // Once the frame has overflowed, pin the sum at full scale until the frame ends.
        if (w_frame_ovf_nxt) begin
            w_acc_nxt = {ACCW{1'b1}};
        end
`endif
    end

    // Operand stage: track position in the frame and register the masked product.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values, regardless of statement order or block order.
        if (!rst) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_prod  <= '0;
        end else if (clr) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_prod <= w_prod;
                r_s1_last <= w_last;
                r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // Accumulate stage: fold non-last products in, restart the frame after the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_frame_ovf <= 1'b0;
        end else if (clr) begin
            r_acc       <= '0;
            r_frame_ovf <= 1'b0;
        end else if (!w_stall && r_s1_valid) begin
            if (r_s1_last) begin
                r_acc       <= '0;
                r_frame_ovf <= 1'b0;
            end else begin
                r_acc       <= w_acc_nxt;
                r_frame_ovf <= w_frame_ovf_nxt;
            end
        end
    end

    // Output register: reload on a finished frame, otherwise drop valid only on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_ovf       <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_c         <= w_acc_nxt;
            r_ovf       <= w_frame_ovf_nxt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign ovf       = r_ovf;

endmodule
